// File: rtl/param_sequence_detector.sv
// Sliding-window sequence detector with a run-time writable pattern,
// overlap/non-overlap match modes, a saturating match counter and a fill level.
module param_sequence_detector #(
  parameter int unsigned DATA_W  = 3,
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter logic [DATA_W*SEQ_LEN-1:0] RESET_PATTERN =
    24'b101_011_110_110_000_110_101_001
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_W-1:0]              data,
  input  logic                           data_valid,
  input  logic                           overlap_en,
  input  logic                           clear,
  input  logic                           pat_wr_en,
  input  logic [$clog2(SEQ_LEN)-1:0]     pat_wr_addr,
  input  logic [DATA_W-1:0]              pat_wr_data,
  output logic                           sequence_found,
  output logic [CNT_W-1:0]               match_count,
  output logic [$clog2(SEQ_LEN+1)-1:0]   fill_level
);

  localparam int unsigned PAT_W  = DATA_W * SEQ_LEN;
  localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);

  // Slot k occupies bits [k*DATA_W +: DATA_W]; slot 0 is the oldest symbol,
  // which lines up the window bit-for-bit with the pattern layout.
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  pattern;

  logic [PAT_W-1:0]  window_shift_c;
  logic [FILL_W-1:0] fill_inc_c;
  logic              accept_c;
  logic              pat_wr_ok_c;
  logic              match_c;

  always_comb begin
    window_shift_c = {data, window[PAT_W-1:DATA_W]};
    fill_inc_c     = (fill_level == FILL_W'(SEQ_LEN)) ? fill_level
                                                      : fill_level + FILL_W'(1);
    accept_c       = data_valid && !pat_wr_en && !clear;
    pat_wr_ok_c    = pat_wr_en && (32'(pat_wr_addr) < SEQ_LEN);
    match_c        = accept_c && (fill_inc_c == FILL_W'(SEQ_LEN)) &&
                     (window_shift_c == pattern);
  end

  // clear outranks pattern writes, which outrank symbol acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window         <= '0;
      pattern        <= RESET_PATTERN;
      fill_level     <= '0;
      match_count    <= '0;
      sequence_found <= 1'b0;
    end else begin
      sequence_found <= match_c;
      if (clear) begin
        fill_level  <= '0;
        match_count <= '0;
      end else if (pat_wr_ok_c) begin
        pattern[32'(pat_wr_addr)*DATA_W +: DATA_W] <= pat_wr_data;
        fill_level <= '0;
      end else if (accept_c) begin
        window     <= window_shift_c;
        fill_level <= (match_c && !overlap_en) ? '0 : fill_inc_c;
        if (match_c && (match_count != '1)) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: a vector table on the default
// instance plus hand-written reset, overlap and saturation sequences.
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] data;
  logic       data_valid;
  logic       overlap_en;
  logic       clear;
  logic       pat_wr_en;
  logic [2:0] pat_wr_addr;
  logic [2:0] pat_wr_data;
  logic       pw_en_4   = 1'b0;
  logic [1:0] pw_addr_4 = 2'd0;
  logic [2:0] pw_data_4 = 3'd0;

  logic       found_a;
  logic [7:0] cnt_a;
  logic [3:0] fill_a;
  logic       found_b;
  logic [7:0] cnt_b;
  logic [2:0] fill_b;
  logic       found_c;
  logic [1:0] cnt_c;
  logic [2:0] fill_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] def_pat = 24'b101_011_110_110_000_110_101_001;

  always #5 clk = ~clk;

  param_sequence_detector dut_a (
    .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
    .overlap_en(overlap_en), .clear(clear), .pat_wr_en(pat_wr_en),
    .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .sequence_found(found_a), .match_count(cnt_a), .fill_level(fill_a)
  );

  param_sequence_detector #(.SEQ_LEN(4), .RESET_PATTERN(12'b110_110_110_110)) dut_b (
    .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
    .overlap_en(overlap_en), .clear(clear), .pat_wr_en(pw_en_4),
    .pat_wr_addr(pw_addr_4), .pat_wr_data(pw_data_4),
    .sequence_found(found_b), .match_count(cnt_b), .fill_level(fill_b)
  );

  param_sequence_detector #(.SEQ_LEN(4), .CNT_W(2), .RESET_PATTERN(12'b110_110_110_110)) dut_c (
    .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
    .overlap_en(overlap_en), .clear(clear), .pat_wr_en(pw_en_4),
    .pat_wr_addr(pw_addr_4), .pat_wr_data(pw_data_4),
    .sequence_found(found_c), .match_count(cnt_c), .fill_level(fill_c)
  );

  typedef struct packed {
    logic       dv;
    logic [2:0] d;
    logic       ov;
    logic       clr;
    logic       pw;
    logic [2:0] pa;
    logic [2:0] pd;
    logic       ef;
    logic [7:0] ec;
    logic [3:0] efl;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] sym(input int i);
    return def_pat[3*i +: 3];
  endfunction

  task automatic add(input logic dv, input logic [2:0] d, input logic ov,
                     input logic clr, input logic pw, input logic [2:0] pa,
                     input logic [2:0] pd, input logic ef, input int ec,
                     input int efl);
    vec_t v;
    v.dv = dv; v.d = d; v.ov = ov; v.clr = clr; v.pw = pw; v.pa = pa; v.pd = pd;
    v.ef = ef; v.ec = 8'(ec); v.efl = 4'(efl);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [2:0] d, input logic ov, input logic clr);
    @(negedge clk);
    data_valid = dv; data = d; overlap_en = ov; clear = clr;
    pat_wr_en = 1'b0; pat_wr_addr = 3'd0; pat_wr_data = 3'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] d;
    // Basic match, then idle keeps the full window in overlap mode.
    for (int i = 0; i < 8; i++) add(1, sym(i), 1, 0, 0, 0, 0, i == 7, (i == 7) ? 1 : 0, i + 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 8);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // data_valid toggling between symbols.
    for (int i = 0; i < 8; i++) begin
      add(1, sym(i), 1, 0, 0, 0, 0, i == 7, (i == 7) ? 1 : 0, i + 1);
      add(0, 3'b111, 1, 0, 0, 0, 0, 0, (i == 7) ? 1 : 0, i + 1);
    end
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // Corrupted 5th symbol never matches.
    for (int i = 0; i < 8; i++) begin
      d = (i == 4) ? 3'b111 : sym(i);
      add(1, d, 1, 0, 0, 0, 0, 0, 0, i + 1);
    end
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // overlap_en flipped mid-stream; non-overlap match empties the window.
    for (int i = 0; i < 8; i++) add(1, sym(i), i < 4, 0, 0, 0, 0, i == 7, (i == 7) ? 1 : 0, (i == 7) ? 0 : i + 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    // Pattern write over a would-be match discards the symbol and the fill.
    for (int i = 0; i < 7; i++) add(1, sym(i), 1, 0, 0, 0, 0, 0, 1, i + 1);
    add(1, 3'b101, 1, 0, 1, 3'd7, 3'b111, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      d = (i == 7) ? 3'b111 : sym(i);
      add(1, d, 1, 0, 0, 0, 0, i == 7, (i == 7) ? 2 : 1, i + 1);
    end
    // clear beats pat_wr_en: pattern stays with 111 last.
    add(1, 3'b111, 1, 1, 1, 3'd7, 3'b000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      d = (i == 7) ? 3'b111 : sym(i);
      add(1, d, 1, 0, 0, 0, 0, i == 7, (i == 7) ? 1 : 0, i + 1);
    end
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, sym(i), 1, 0, 0, 0, 0, 0, 0, i + 1);
    for (int i = 0; i < 8; i++) begin
      d = (i == 7) ? 3'b111 : sym(i);
      add(1, d, 1, 0, 0, 0, 0, i == 7, (i == 7) ? 1 : 0, 8);
    end

    reset_n = 1'b0; data_valid = 1'b0; data = 3'd0; overlap_en = 1'b1; clear = 1'b0;
    pat_wr_en = 1'b0; pat_wr_addr = 3'd0; pat_wr_data = 3'd0;
    #1;
    chk("reset.found", 32'(found_a), 0);
    chk("reset.count", 32'(cnt_a), 0);
    chk("reset.fill", 32'(fill_a), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      data_valid = tbl[i].dv; data = tbl[i].d; overlap_en = tbl[i].ov;
      clear = tbl[i].clr; pat_wr_en = tbl[i].pw; pat_wr_addr = tbl[i].pa;
      pat_wr_data = tbl[i].pd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.found", i), 32'(found_a), 32'(tbl[i].ef));
      chk($sformatf("v%0d.count", i), 32'(cnt_a), 32'(tbl[i].ec));
      chk($sformatf("v%0d.fill", i), 32'(fill_a), 32'(tbl[i].efl));
    end

    // Asynchronous reset mid-sequence drops progress and restores the pattern.
    for (int i = 0; i < 6; i++) step(1, sym(i), 1, 0);
    chk("pre_rst.count", 32'(cnt_a), 1);
    reset_n = 1'b0;
    #2;
    chk("rst_async.found", 32'(found_a), 0);
    chk("rst_async.count", 32'(cnt_a), 0);
    chk("rst_async.fill", 32'(fill_a), 0);
    @(negedge clk);
    data_valid = 1'b0;
    reset_n = 1'b1;
    step(1, sym(6), 1, 0);
    step(1, sym(7), 1, 0);
    chk("post_rst.found", 32'(found_a), 0);
    chk("post_rst.fill", 32'(fill_a), 2);
    for (int i = 0; i < 8; i++) step(1, sym(i), 1, 0);
    chk("restored.found", 32'(found_a), 1);
    chk("restored.count", 32'(cnt_a), 1);

    // SEQ_LEN=4, all-110 pattern: overlap, saturation and non-overlap.
    step(0, 0, 1, 1);
    chk("b_clr.fill", 32'(fill_b), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'b110, 1, 0);
      chk($sformatf("b_ov%0d.found", i), 32'(found_b), 32'(i >= 3));
      chk($sformatf("b_ov%0d.count", i), 32'(cnt_b), (i >= 3) ? i - 2 : 0);
      chk($sformatf("c_ov%0d.count", i), 32'(cnt_c), (i >= 5) ? 3 : ((i >= 3) ? i - 2 : 0));
      chk($sformatf("c_ov%0d.fill", i), 32'(fill_c), (i >= 3) ? 4 : i + 1);
    end
    step(0, 0, 1, 1);
    chk("c_clr.count", 32'(cnt_c), 0);
    chk("c_clr.fill", 32'(fill_c), 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 3'b110, 0, 0);
      chk($sformatf("b_nov%0d.found", i), 32'(found_b), 32'(i == 3));
      chk($sformatf("b_nov%0d.fill", i), 32'(fill_b), (i < 3) ? i + 1 : i - 3);
    end
    chk("b_nov.count", 32'(cnt_b), 1);
    chk("b_nov.fill_end", 32'(fill_b), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
